inst_dec_pipe: RTL and testbench

//   Pipelined, parametrised successor to inst_dec.

---
 rtl/dec_pkg.sv | 41 ++++
 rtl/inst_dec_field.sv | 59 +++++
 rtl/inst_dec_pipe.sv | 131 +++++++++++++
 tb/tb_inst_dec_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Package dec_pkg
//   Shared definitions for the pipelined instruction decoder:
//   opcode constants, instruction field bit positions, default
//   write-back / illegal opcode masks and the decoded-bundle struct.
//   Optional feature macro used by the importing modules: DEC_ILLEGAL_TRAP_EN.
package dec_pkg;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int SELD_MSB = 11;
  localparam int SELD_LSB = 9;
  localparam int FLAG_BIT = 8;
  localparam int SELA_MSB = 7;
  localparam int SELA_LSB = 5;
  localparam int SELB_MSB = 4;
  localparam int SELB_LSB = 2;
  localparam int IMM8_MSB = 7;
  localparam int IMM8_LSB = 0;

  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_BR   = 4'hC;
  localparam logic [3:0] OP_BRC  = 4'hD;
  localparam logic [3:0] OP_TRAP = 4'hF;

  // Opcodes that never write the register file.
  localparam logic [15:0] NOWB_MASK_DEF = (16'd1 << OP_ST) | (16'd1 << OP_BR) |
                                          (16'd1 << OP_BRC) | (16'd1 << OP_TRAP);
  localparam logic [15:0] ILL_MASK_DEF  = 16'd1 << OP_TRAP;

  // Width-independent part of the decoded bundle; selects are kept at their
  // raw 3-bit size and widened at the decoder output ports.
  typedef struct packed {
    logic [4:0] aluop;
    logic [2:0] sel_d;
    logic [2:0] sel_a;
    logic [2:0] sel_b;
    logic       regwe;
    logic       illegal;
  } dec_bundle_t;

endpackage

// File: rtl/inst_dec_field.sv
// Module inst_dec_field
//   Combinational decode of one 16-bit instruction word into the ALU op,
//   register selects, write-enable, illegal flag and XLEN-wide immediate.
//   Optional feature: DEC_ILLEGAL_TRAP_EN (illegal-opcode flagging; illegal
//   opcodes also suppress write-back). Without it the illegal flag is 0.
// Ports
//   inst  in   16    instruction word
//   bndl  out  struct decoded fields (dec_bundle_t)
//   imm   out  XLEN  expanded immediate
module inst_dec_field
  import dec_pkg::*;
#(
  parameter int          XLEN      = 16,
  parameter logic [15:0] NOWB_MASK = NOWB_MASK_DEF,
  parameter logic [15:0] ILL_MASK  = ILL_MASK_DEF
) (
  input  logic [15:0]     inst,
  output dec_bundle_t     bndl,
  output logic [XLEN-1:0] imm
);

  // flag=1: imm8 replicated into the upper 16 bits, zeros below.
  // flag=0: imm8 sign-extended to XLEN.
  function automatic logic [XLEN-1:0] expand_imm(input logic flag, input logic [7:0] imm8);
    logic [XLEN-1:0] rep;
    rep = XLEN'({imm8, imm8}) << (XLEN - 16);
    if (flag) return rep;
    return {{(XLEN-8){imm8[7]}}, imm8};
  endfunction

  logic [3:0] opc;
  logic [7:0] imm8;
  logic       flag;

  assign opc  = inst[OPC_MSB:OPC_LSB];
  assign imm8 = inst[IMM8_MSB:IMM8_LSB];
  assign flag = inst[FLAG_BIT];

`ifndef DEC_ILLEGAL_TRAP_EN
  localparam logic [15:0] unused_ill_mask = ILL_MASK;
`endif

  always_comb begin
    bndl       = '0;
    bndl.aluop = {opc, flag};
    bndl.sel_d = inst[SELD_MSB:SELD_LSB];
    bndl.sel_a = inst[SELA_MSB:SELA_LSB];
    bndl.sel_b = inst[SELB_MSB:SELB_LSB];
`ifdef DEC_ILLEGAL_TRAP_EN
    bndl.illegal = ILL_MASK[opc];
    bndl.regwe   = ~NOWB_MASK[opc] & ~ILL_MASK[opc];
`else
    bndl.illegal = 1'b0;
    bndl.regwe   = ~NOWB_MASK[opc];
`endif
    imm = expand_imm(flag, imm8);
  end

endmodule

// File: rtl/inst_dec_pipe.sv
// Module inst_dec_pipe
//   Pipelined instruction decoder between fetch and register-file/ALU issue.
//   One 16-bit instruction per cycle, valid/ready on both sides, with a
//   one-entry skid register behind the output register so an instruction
//   accepted while downstream stalls is never lost. o_ready is derived only
//   from registered state.
//   Optional feature: DEC_ILLEGAL_TRAP_EN -- o_illegal reports illegal opcodes
//   and, once an illegal bundle retires, o_ready is held low until I_flush or
//   I_rst. Undefined: o_illegal is always 0.
// Ports
//   I_clk, I_rst      clock, synchronous active-high reset
//   I_en              clock enable (flush and reset act regardless)
//   I_flush           discard held instructions
//   I_valid/o_ready   upstream handshake, I_inst instruction word
//   o_valid/I_ready   downstream handshake
//   o_aluop, o_selD, o_selA, o_selB, o_imm, o_regwe, o_illegal  decoded bundle
module inst_dec_pipe
  import dec_pkg::*;
#(
  parameter int          XLEN      = 16,
  parameter int          SEL_W     = 4,
  parameter logic [15:0] NOWB_MASK = NOWB_MASK_DEF,
  parameter logic [15:0] ILL_MASK  = ILL_MASK_DEF
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_en,
  input  logic             I_flush,
  input  logic             I_valid,
  output logic             o_ready,
  input  logic [15:0]      I_inst,
  output logic             o_valid,
  input  logic             I_ready,
  output logic [4:0]       o_aluop,
  output logic [SEL_W-1:0] o_selD,
  output logic [SEL_W-1:0] o_selA,
  output logic [SEL_W-1:0] o_selB,
  output logic [XLEN-1:0]  o_imm,
  output logic             o_regwe,
  output logic             o_illegal
);

  // State encoding is {skid_v, out_v}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t          state, state_nx;
  logic            skid_v, vld_p1, trap_lock;
  logic            accept, retire, load_out, load_skid;
  logic [15:0]     skid_inst_p0, dec_src;
  dec_bundle_t     dec_bndl, bndl_p1;
  logic [XLEN-1:0] dec_imm, imm_p1;

  assign skid_v  = (state == ST_FULL);
  assign vld_p1  = (state != ST_EMPTY);
  assign o_ready = ~skid_v & ~trap_lock;
  assign accept  = I_en & I_valid & o_ready;
  assign retire  = I_en & vld_p1 & I_ready;

  always_comb begin
    state_nx = state;
    case (state)
      ST_EMPTY: if (accept) state_nx = ST_ONE;
      ST_ONE: begin
        if (accept && !retire)      state_nx = ST_FULL;
        else if (!accept && retire) state_nx = ST_EMPTY;
      end
      ST_FULL:  if (retire) state_nx = ST_ONE;
      default:  state_nx = ST_EMPTY;
    endcase
    if (I_flush) state_nx = ST_EMPTY;
  end

  always_ff @(posedge I_clk) begin
    if (I_rst)                state <= ST_EMPTY;
    else if (I_flush || I_en) state <= state_nx;
  end

`ifdef DEC_ILLEGAL_TRAP_EN
  always_ff @(posedge I_clk) begin
    if (I_rst || I_flush)                 trap_lock <= 1'b0;
    else if (retire && bndl_p1.illegal)   trap_lock <= 1'b1;
  end
`else
  assign trap_lock = 1'b0;
`endif

  // A flush discards any same-cycle accept, so neither register loads.
  assign load_out  = I_en & ~I_flush & (~vld_p1 | retire) & (skid_v | accept);
  assign load_skid = I_en & ~I_flush & accept & (state == ST_ONE) & ~retire;
  assign dec_src   = skid_v ? skid_inst_p0 : I_inst;

  // ---- stage p0: skid register (holds raw instruction word) ----
  always_ff @(posedge I_clk) begin
    if (load_skid) skid_inst_p0 <= I_inst;
  end

  inst_dec_field #(
    .XLEN      (XLEN),
    .NOWB_MASK (NOWB_MASK),
    .ILL_MASK  (ILL_MASK)
  ) u_field (
    .inst (dec_src),
    .bndl (dec_bndl),
    .imm  (dec_imm)
  );

  // ---- stage p1: output bundle register ----
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      bndl_p1 <= '0;
      imm_p1  <= '0;
    end else if (load_out) begin
      bndl_p1 <= dec_bndl;
      imm_p1  <= dec_imm;
    end
  end

  assign o_valid   = vld_p1;
  assign o_aluop   = bndl_p1.aluop;
  assign o_selD    = SEL_W'(bndl_p1.sel_d);
  assign o_selA    = SEL_W'(bndl_p1.sel_a);
  assign o_selB    = SEL_W'(bndl_p1.sel_b);
  assign o_imm     = imm_p1;
  assign o_regwe   = bndl_p1.regwe;
  assign o_illegal = bndl_p1.illegal;

endmodule

// File: tb/tb_inst_dec_pipe.sv
// Testbench for inst_dec_pipe (default parameters, XLEN=16, SEL_W=4).
// Directed vectors with hand-computed decode results feed a scoreboard
// queue on acceptance; a separate monitor pops on every retire.
module tb_inst_dec_pipe;

`ifdef DEC_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic        I_clk = 1'b0;
  logic        I_rst, I_en, I_flush, I_valid, I_ready;
  logic [15:0] I_inst;
  logic        o_ready, o_valid, o_regwe, o_illegal;
  logic [4:0]  o_aluop;
  logic [3:0]  o_selD, o_selA, o_selB;
  logic [15:0] o_imm;

  always #5 I_clk = ~I_clk;

  inst_dec_pipe dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_en(I_en), .I_flush(I_flush),
    .I_valid(I_valid), .o_ready(o_ready), .I_inst(I_inst),
    .o_valid(o_valid), .I_ready(I_ready),
    .o_aluop(o_aluop), .o_selD(o_selD), .o_selA(o_selA), .o_selB(o_selB),
    .o_imm(o_imm), .o_regwe(o_regwe), .o_illegal(o_illegal)
  );

  typedef struct {
    logic [15:0] inst;
    logic [4:0]  aluop;
    logic [3:0]  d, a, b;
    logic [15:0] imm;
    logic        we;
    logic        ill;
  } vec_t;

  vec_t vec [12];
  vec_t q [$];
  vec_t cur_exp;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic accepted;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; accept is judged at the
  // falling edge where o_ready and the inputs are both settled.
  task automatic cycle();
    @(negedge I_clk);
    accepted = !I_rst && I_en && !I_flush && I_valid && o_ready;
    if (accepted) q.push_back(cur_exp);
    @(posedge I_clk);
    #1;
    cyc++;
  endtask

  task automatic send(input int idx);
    int n;
    n = 0;
    I_valid = 1'b1;
    I_inst  = vec[idx].inst;
    cur_exp = vec[idx];
    accepted = 1'b0;
    while (!accepted && n < 40) begin
      cycle();
      n++;
    end
    if (!accepted) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_ready"}, o_ready, 1);
    chk({tag, "_aluop"}, o_aluop, 0);
    chk({tag, "_sel"},   {o_selD, o_selA, o_selB}, 0);
    chk({tag, "_imm"},   o_imm, 0);
    chk({tag, "_regwe"}, o_regwe, 0);
    chk({tag, "_ill"},   o_illegal, 0);
  endtask

  // Monitor: compare every retiring bundle against the scoreboard head.
  initial begin
    vec_t e;
    forever begin
      @(negedge I_clk);
      if (I_rst) begin
        q.delete();
      end else begin
        if (o_valid && I_ready && I_en) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bundle: got aluop %0h imm %0h, required no bundle", o_aluop, o_imm);
          end else begin
            e = q.pop_front();
            chk("aluop", o_aluop, e.aluop);
            chk("selD",  o_selD,  e.d);
            chk("selA",  o_selA,  e.a);
            chk("selB",  o_selB,  e.b);
            chk("imm",   o_imm,   e.imm);
            chk("regwe", o_regwe, e.we);
            chk("ill",   o_illegal, e.ill);
          end
        end
        if (I_flush) q.delete();
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    //               inst      aluop  D  A  B  imm       we    ill
    vec[0]  = '{16'hE004, 5'h1C, 0, 0, 1, 16'h0004, 1'b1, 1'b0};
    vec[1]  = '{16'h31FF, 5'h07, 0, 7, 7, 16'hFFFF, 1'b1, 1'b0};
    vec[2]  = '{16'h30FF, 5'h06, 0, 7, 7, 16'hFFFF, 1'b1, 1'b0};
    vec[3]  = '{16'hB000, 5'h16, 0, 0, 0, 16'h0000, 1'b0, 1'b0};
    vec[4]  = '{16'h1A5C, 5'h02, 5, 2, 7, 16'h005C, 1'b1, 1'b0};
    vec[5]  = '{16'h2B80, 5'h05, 5, 4, 0, 16'h8080, 1'b1, 1'b0};
    vec[6]  = '{16'h4E81, 5'h08, 7, 4, 0, 16'hFF81, 1'b1, 1'b0};
    vec[7]  = '{16'hC7F0, 5'h19, 3, 7, 4, 16'hF0F0, 1'b0, 1'b0};
    vec[8]  = '{16'hD212, 5'h1A, 1, 0, 4, 16'h0012, 1'b0, 1'b0};
    vec[9]  = '{16'hF000, 5'h1E, 0, 0, 0, 16'h0000, 1'b0, TRAP};
    vec[10] = '{16'h5678, 5'h0A, 3, 3, 6, 16'h0078, 1'b1, 1'b0};
    vec[11] = '{16'h8A55, 5'h10, 5, 2, 5, 16'h0055, 1'b1, 1'b0};

    I_rst = 1'b1; I_en = 1'b1; I_flush = 1'b0; I_valid = 1'b0;
    I_inst = 16'h0; I_ready = 1'b1; cur_exp = vec[0];
    @(posedge I_clk); #1;
    cycle();
    rst_chk("reset");
    I_rst = 1'b0;

    // Single instruction: visible the cycle after acceptance.
    send(0);
    chk("latency_valid", o_valid, 1);
    I_valid = 1'b0;
    repeat (2) cycle();

    // Back-to-back stream at full throughput.
    c0 = cyc;
    for (int i = 1; i <= 4; i++) send(i);
    chk("throughput_cycles", cyc - c0, 4);
    I_valid = 1'b0;
    repeat (3) cycle();

    // Backpressure: two accepted, then ready drops and bundle holds.
    I_ready = 1'b0;
    send(5);
    send(6);
    chk("bp_ready_low", o_ready, 0);
    I_valid = 1'b1; I_inst = vec[7].inst; cur_exp = vec[7];
    repeat (3) begin
      cycle();
      chk("bp_no_accept", accepted, 0);
      chk("bp_valid", o_valid, 1);
      chk("bp_hold_aluop", o_aluop, 5'h05);
      chk("bp_hold_imm", o_imm, 16'h8080);
    end
    I_ready = 1'b1;
    send(7);
    send(8);
    I_valid = 1'b0;
    repeat (4) cycle();

    // Clock enable low: no accept, no retire, outputs frozen.
    send(10);
    I_en = 1'b0; I_valid = 1'b1; I_inst = vec[11].inst; cur_exp = vec[11];
    repeat (2) begin
      cycle();
      chk("en_no_accept", accepted, 0);
      chk("en_valid", o_valid, 1);
      chk("en_hold_aluop", o_aluop, 5'h0A);
    end
    I_en = 1'b1;
    send(11);
    I_valid = 1'b0;
    repeat (3) cycle();

    // Flush while FULL with a pending instruction at the input.
    I_ready = 1'b0;
    send(1);
    send(2);
    chk("fl_full_ready", o_ready, 0);
    I_valid = 1'b1; I_inst = vec[3].inst; cur_exp = vec[3]; I_flush = 1'b1;
    cycle();
    chk("fl_valid", o_valid, 0);
    chk("fl_ready", o_ready, 1);
    I_flush = 1'b0; I_valid = 1'b0; I_ready = 1'b1;
    repeat (3) cycle();
    chk("fl_quiet", o_valid, 0);

    // Opcode F: no write-back; with trap enabled ready stays low until flush.
    send(9);
    I_valid = 1'b0;
    repeat (3) cycle();
    chk("trap_ready", o_ready, TRAP ? 0 : 1);
    I_flush = 1'b1;
    cycle();
    I_flush = 1'b0;
    chk("trap_cleared", o_ready, 1);

    // Reset mid-stream while FULL.
    I_ready = 1'b0;
    send(4);
    send(5);
    I_valid = 1'b1; I_inst = vec[6].inst; cur_exp = vec[6]; I_rst = 1'b1;
    cycle();
    rst_chk("midrst");
    I_rst = 1'b0; I_ready = 1'b1;
    send(0);
    I_valid = 1'b0;
    repeat (3) cycle();
    chk("sb_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
